// File: rtl/slt_iter_cmp.sv
// slt_iter_cmp: multi-cycle set-on-compare (SLT/SLTU/SEQ/SNE), DIGIT bits per cycle, MSB chunk first.
// The zero-extended 0/1 result is returned over a valid/ready handshake.
module slt_iter_cmp #(
  parameter int WIDTH      = 32,
  parameter int DIGIT      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;
  localparam logic [1:0] OP_SNE  = 2'b11;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [1:0]       op_q;
  logic [IDXW-1:0]  idx;
  logic             lt_q;
  logic             diff_q;

  logic [DIGIT-1:0] chunk_a;
  logic [DIGIT-1:0] chunk_b;
  logic             chunk_diff;
  logic             lt_next;
  logic             diff_next;
  logic             last_chunk;
  logic             finish;
  logic             flag;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;

  always_comb begin
    chunk_a    = sh_a[WIDTH-1 -: DIGIT];
    chunk_b    = sh_b[WIDTH-1 -: DIGIT];
    chunk_diff = (chunk_a != chunk_b);
    // Only the first differing chunk decides the ordering; later chunks are ignored.
    diff_next  = diff_q | chunk_diff;
    lt_next    = diff_q ? lt_q : (chunk_a < chunk_b);
    last_chunk = (idx == LAST_IDX);
    finish     = last_chunk || ((EARLY_EXIT != 0) && chunk_diff && !diff_q);
    case (op_q)
      OP_SEQ:  flag = ~diff_next;
      OP_SNE:  flag = diff_next;
      default: flag = lt_next;
    endcase
    // Flipping the sign bits turns a signed compare into an unsigned one.
    cap_a = a;
    cap_b = b;
    if (op == OP_SLT) begin
      cap_a[WIDTH-1] = ~a[WIDTH-1];
      cap_b[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_CMP) || (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      result <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      op_q   <= OP_SLTU;
      idx    <= '0;
      lt_q   <= 1'b0;
      diff_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sh_a   <= cap_a;
            sh_b   <= cap_b;
            op_q   <= op;
            idx    <= '0;
            lt_q   <= 1'b0;
            diff_q <= 1'b0;
            state  <= S_CMP;
          end
        end
        S_CMP: begin
          sh_a   <= sh_a << DIGIT;
          sh_b   <= sh_b << DIGIT;
          idx    <= idx + 1'b1;
          lt_q   <= lt_next;
          diff_q <= diff_next;
          if (finish) begin
            result <= {{(WIDTH-1){1'b0}}, flag};
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
